// File: rtl/mtpsa_digest_extract_if.sv
// AXI4-Stream bundle used on both sides of the digest extractor.
// The slave modport is the receiving side, the master modport the driving side.
interface mtpsa_digest_extract_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 296
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mtpsa_digest_extract.sv
// Digest extractor behind the user0 SDNet stage: forwards the packet stream through
// a 2-entry skid slice with tuser narrowed to the SUME format, and captures the digest
// of flagged packets (first beat only) into a FWFT FIFO. Digest back-pressure never
// stalls packets; digests that find the FIFO full are dropped and counted.
module mtpsa_digest_extract #(
    parameter int C_AXIS_DATA_WIDTH    = 256,
    parameter int DIGEST_WIDTH         = 256,
    parameter int META_WIDTH           = 40,
    parameter int C_S_AXIS_TUSER_WIDTH = 296,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DIGEST_FIFO_DEPTH    = 8
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    mtpsa_digest_extract_if.slave                s_axis,
    mtpsa_digest_extract_if.master               m_axis,
    output logic [DIGEST_WIDTH-1:0]              dig_tdata,
    output logic                                 dig_tvalid,
    input  logic                                 dig_tready,
    output logic [31:0]                          dig_drop_cnt,
    output logic [$clog2(DIGEST_FIFO_DEPTH):0]   dig_fifo_level
);
    localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
    localparam int AW         = $clog2(DIGEST_FIFO_DEPTH);
    localparam int LW         = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DIGEST_FIFO_DEPTH);

    typedef enum logic [0:0] {ST_SOP = 1'b0, ST_IN_PKT = 1'b1} state_t;

    state_t                       state_r, state_next_s;

    // Skid slice: output stage plus one overflow entry
    logic                         out_valid_r, out_valid_next_s;
    logic [C_AXIS_DATA_WIDTH-1:0] out_data_r;
    logic [KEEP_WIDTH-1:0]        out_keep_r;
    logic [31:0]                  out_meta_r;
    logic                         out_last_r;
    logic                         skid_valid_r, skid_valid_next_s;
    logic [C_AXIS_DATA_WIDTH-1:0] skid_data_r;
    logic [KEEP_WIDTH-1:0]        skid_keep_r;
    logic [31:0]                  skid_meta_r;
    logic                         skid_last_r;
    logic                         ready_r;
    logic                         accept_s, out_free_s;
    logic                         load_from_skid_s, load_from_in_s, load_skid_s;

    // Digest FIFO
    logic [DIGEST_WIDTH-1:0]      fifo_mem_r [DIGEST_FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]                level_r, level_next_s;
    logic                         dig_valid_r;
    logic [31:0]                  drop_cnt_r;
    logic                         capture_s, push_s, pop_s, drop_s, full_s;
    logic                         unused_meta_s;

    // Metadata bits above the forwarded 32 (other than the send flag) have no consumer here.
    assign unused_meta_s = ^s_axis.tuser[META_WIDTH-1:33];

    assign accept_s   = s_axis.tvalid & ready_r;
    assign out_free_s = ~out_valid_r | m_axis.tready;

    // Skid slice steering: refill the output stage from the skid first, else from the input.
    always_comb begin
        out_valid_next_s  = out_valid_r;
        skid_valid_next_s = skid_valid_r;
        load_from_skid_s  = 1'b0;
        load_from_in_s    = 1'b0;
        load_skid_s       = 1'b0;
        if (out_free_s) begin
            if (skid_valid_r) begin
                load_from_skid_s  = 1'b1;
                out_valid_next_s  = 1'b1;
                skid_valid_next_s = 1'b0;
            end else if (accept_s) begin
                load_from_in_s   = 1'b1;
                out_valid_next_s = 1'b1;
            end else begin
                out_valid_next_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                load_skid_s       = 1'b1;
                skid_valid_next_s = 1'b1;
            end else begin
                skid_valid_next_s = skid_valid_r;
            end
        end
    end

    // Skid slice control flags; ready is low through reset and then tracks "skid empty".
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_next_s;
            skid_valid_r <= skid_valid_next_s;
            ready_r      <= ~skid_valid_next_s;
        end
    end

    // Skid slice payload registers; held unchanged while the output is stalled.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_meta_r  <= 32'd0;
            out_last_r  <= 1'b0;
            skid_data_r <= '0;
            skid_keep_r <= '0;
            skid_meta_r <= 32'd0;
            skid_last_r <= 1'b0;
        end else begin
            if (load_from_skid_s) begin
                out_data_r <= skid_data_r;
                out_keep_r <= skid_keep_r;
                out_meta_r <= skid_meta_r;
                out_last_r <= skid_last_r;
            end else if (load_from_in_s) begin
                out_data_r <= s_axis.tdata;
                out_keep_r <= s_axis.tkeep;
                out_meta_r <= s_axis.tuser[31:0];
                out_last_r <= s_axis.tlast;
            end
            if (load_skid_s) begin
                skid_data_r <= s_axis.tdata;
                skid_keep_r <= s_axis.tkeep;
                skid_meta_r <= s_axis.tuser[31:0];
                skid_last_r <= s_axis.tlast;
            end
        end
    end

    // Packet boundary tracker: next state from accepted beats and their tlast.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SOP: begin
                if (accept_s && !s_axis.tlast) state_next_s = ST_IN_PKT;
                else                           state_next_s = ST_SOP;
            end
            ST_IN_PKT: begin
                if (accept_s && s_axis.tlast) state_next_s = ST_SOP;
                else                          state_next_s = ST_IN_PKT;
            end
            default: state_next_s = ST_SOP;
        endcase
    end

    // Packet boundary state register.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) state_r <= ST_SOP;
        else              state_r <= state_next_s;
    end

    // Digest FIFO push/pop/drop decisions; a same-cycle pop frees the slot for a push.
    always_comb begin
        pop_s     = dig_valid_r & dig_tready;
        full_s    = (level_r == FULL_LEVEL);
        capture_s = accept_s & (state_r == ST_SOP) & s_axis.tuser[32];
        push_s    = capture_s & (~full_s | pop_s);
        drop_s    = capture_s & full_s & ~pop_s;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Digest FIFO pointers, occupancy, valid flag and saturating drop counter.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            dig_valid_r <= 1'b0;
            drop_cnt_r  <= 32'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r     <= level_next_s;
            dig_valid_r <= (level_next_s != '0);
            if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) drop_cnt_r <= drop_cnt_r + 32'd1;
        end
    end

    // Digest FIFO storage; contents are only meaningful behind the pointers.
    always_ff @(posedge axis_aclk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:META_WIDTH];
    end

    assign s_axis.tready  = ready_r;
    assign m_axis.tvalid  = out_valid_r;
    assign m_axis.tdata   = out_data_r;
    assign m_axis.tkeep   = out_keep_r;
    assign m_axis.tlast   = out_last_r;
    assign m_axis.tuser   = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, out_meta_r};
    assign dig_tdata      = fifo_mem_r[rd_ptr_r];
    assign dig_tvalid     = dig_valid_r;
    assign dig_drop_cnt   = drop_cnt_r;
    assign dig_fifo_level = level_r;
endmodule

// File: doc/mtpsa_digest_extract.md
Name: mtpsa_digest_extract

Overview:
- Sits directly downstream of the user0 SDNet wrapper stage and consumes its packet stream, whose wide tuser is {digest[255:0], metadata[39:0]}.
- Forwards packets with tuser narrowed to the 128-bit SUME format.
- On the first beat of each packet flagged send_dig_to_cpu, captures the 256-bit digest into a small FIFO for the CPU/DMA digest path.
- Digest back-pressure never stalls the packet path; overflowing digests are dropped and counted.

Parameters:
C_AXIS_DATA_WIDTH, 256, packet data width (tkeep = width/8)
DIGEST_WIDTH, 256, digest field width
META_WIDTH, 40, metadata field width at the bottom of the input tuser
C_S_AXIS_TUSER_WIDTH, 296, input tuser width = DIGEST_WIDTH + META_WIDTH
C_M_AXIS_TUSER_WIDTH, 128, output tuser width
DIGEST_FIFO_DEPTH, 8, digest FIFO entries; power of two, at least 2

Ports:
axis_aclk  in  1  single clock for all logic
axis_resetn  in  1  asynchronous, active-low reset
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input packet data
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  input byte enables
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  {digest, metadata}; meta[15:0] len, [23:16] src, [31:24] dst, bit 32 send_dig_to_cpu
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output data
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  output byte enables
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  {96'b0, meta[31:0]}
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of packet
dig_tdata  out  DIGEST_WIDTH  head-of-FIFO digest
dig_tvalid  out  1  FIFO not empty
dig_tready  in  1  consumer pops on dig_tvalid & dig_tready
dig_drop_cnt  out  32  saturating count of dropped digests
dig_fifo_level  out  $clog2(DIGEST_FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release on axis_aclk):
  - m_axis_tvalid = 0, dig_tvalid = 0, dig_drop_cnt = 0, dig_fifo_level = 0.
  - s_axis_tready = 1 from the first clock after reset release.
  - FSM enters SOP; skid and FIFO contents are discarded.
  - Reset mid-packet discards the partial packet; the first beat accepted after reset is treated as a SOP.
- Packet path: 2-entry skid register slice.
  - Latency is 1 cycle from accepted input beat to m_axis_tvalid.
  - Sustains 1 beat/cycle while m_axis_tready = 1.
  - s_axis_tready is registered and equals "skid entry empty".
  - Beat order, tdata, tkeep and tlast pass through unchanged.
  - m_axis_tuser = meta[31:0] zero-extended to 128 bits; bits [39:32] are not forwarded.
  - Held outputs stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Beat acceptance: an input beat is accepted when s_axis_tvalid & s_axis_tready.
- FSM, two states:
  - SOP: on an accepted beat with tlast = 0, go to IN_PKT. With tlast = 1 (single-beat packet), stay in SOP.
  - IN_PKT: on an accepted beat with tlast = 1, go to SOP. Otherwise stay.
- Digest capture happens only on an accepted beat while in SOP, and only when s_axis_tuser[32] = 1.
  - FIFO not full, or a pop occurs in the same cycle: push s_axis_tuser[295:40].
  - FIFO full and no pop that cycle: do not push; dig_drop_cnt increments, saturating at 0xFFFFFFFF.
  - Digest/tuser values on IN_PKT beats are ignored.
- Digest FIFO:
  - First-word fall-through: dig_tdata is valid whenever dig_tvalid = 1.
  - Read and write pointers wrap modulo DIGEST_FIFO_DEPTH.
  - Simultaneous push and pop: level unchanged. When empty, a push is visible the next cycle (FIFO latency 1).
  - A pop while empty is ignored.
- The digest FIFO state never affects s_axis_tready or m_axis_tvalid.

Test Plan:
- Reset then a 3-beat packet, meta = 0x1_0401_0040, digest = 0xAA..AA, m_axis_tready = 1 -> 3 output beats, each 1 cycle after its input; m_axis_tuser = 0x0401_0040; dig_tvalid rises with dig_tdata = 0xAA..AA; dig_fifo_level = 1.
- Single-beat packets back to back, 10 packets alternating bit32 = 1/0 -> exactly 5 digests queued in order; no bubbles on m_axis; FSM stays in SOP throughout.
- m_axis_tready toggling 1/0 every cycle during a 4-beat packet -> no beat lost or duplicated; s_axis_tready deasserts only when the skid is full; outputs stable while stalled.
- dig_tready = 0, 10 flagged packets, DEPTH = 8 -> level = 8, dig_drop_cnt = 2; the first 8 digests are retained in order.
- FIFO full, then a flagged SOP arrives in the same cycle as dig_tready = 1 -> push accepted; level stays 8; dig_drop_cnt unchanged.
- axis_resetn asserted mid-packet (beat 2 of 4) -> outputs clear immediately; the next accepted beat is treated as SOP and its digest is captured if flagged.
